// File: rtl/register_file_sb.sv
// 2-read/1-write register file with per-register busy scoreboard and a counted init sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_sb #(
    parameter int N      = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_register1,
    input  logic [ADDR_W-1:0] read_register2,
    output logic [N-1:0]      read_data1,
    output logic [N-1:0]      read_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [N-1:0]      write_data,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_register,
    output logic              ready
);

    typedef enum logic {INIT, READY} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic [DEPTH-1:0]  busy;
    logic [N-1:0]      registers [DEPTH];
    logic              wr_ok, mk_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    assign wr_ok = ready && reg_write && in_range(write_register);
    assign mk_ok = ready && mark_en && in_range(mark_register);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_cnt == LAST) state_nxt = READY;
    end

    always_comb begin
        ready = (state == READY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                init_cnt <= '0;
        else if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end

    // Mark is applied after the write clear so a same-register collision leaves busy set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_ok) busy[write_register] <= 1'b0;
            if (mk_ok) busy[mark_register]  <= 1'b1;
        end
    end

    // Storage has no reset so it can map onto RAM; the sweep provides the initial contents.
    always_ff @(posedge clk) begin
        if (state == INIT) registers[init_cnt] <= N'(init_cnt);
        else if (wr_ok)    registers[write_register] <= write_data;
    end

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        busy1      = 1'b0;
        busy2      = 1'b0;
        if (ready) begin
            if (in_range(read_register1)) begin
                read_data1 = registers[read_register1];
                busy1      = busy[read_register1];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && write_register == read_register1) begin
                    read_data1 = write_data;
                    busy1      = mk_ok && mark_register == read_register1;
                end
`endif
            end
            if (in_range(read_register2)) begin
                read_data2 = registers[read_register2];
                busy2      = busy[read_register2];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && write_register == read_register2) begin
                    read_data2 = write_data;
                    busy2      = mk_ok && mark_register == read_register2;
                end
`endif
            end
        end
    end

endmodule
